// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth decoder / accumulator.
// Latches an unsigned multiplicand on start, then accepts one Booth digit per
// handshake (LSB digit first, select format 1x/2x/sign) and accumulates the
// signed partial product pp_i * 4^i into a two's-complement accumulator.
//
// Ports:
//   Clk_CI, Rst_RI                 clock, synchronous active-high reset
//   Start_SI, Operand_a_DI         start request and multiplicand (IDLE only)
//   Ready_SO                       idle, start may be accepted
//   Digit_valid_SI, Sel_1x_SI,
//   Sel_2x_SI, Sel_sign_SI         Booth digit in encoder select format
//   Digit_ready_SO                 digit accepted this cycle when valid
//   Result_valid_SO, Result_DO     product, held until consumed
//   Result_ready_SI                consumer takes the result
//   Err_SO                         sticky: illegal (1x & 2x) digit seen
module booth_pp_accumulator #(
  parameter int unsigned C_WIDTH = 24,
  parameter int unsigned C_NDIG  = 13,
  parameter int unsigned C_RES_W = C_WIDTH + 2 * C_NDIG + 1
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Start_SI,
  input  logic [C_WIDTH-1:0] Operand_a_DI,
  output logic               Ready_SO,
  input  logic               Digit_valid_SI,
  input  logic               Sel_1x_SI,
  input  logic               Sel_2x_SI,
  input  logic               Sel_sign_SI,
  output logic               Digit_ready_SO,
  output logic               Result_valid_SO,
  output logic [C_RES_W-1:0] Result_DO,
  input  logic               Result_ready_SI,
  output logic               Err_SO
);

  localparam int unsigned CNT_W = (C_NDIG > 1) ? $clog2(C_NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(C_NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [C_WIDTH-1:0]   a_q, a_d;
  logic [C_RES_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [C_WIDTH:0]     mag;
  logic [C_RES_W-1:0]   mag_ext;
  logic [C_RES_W-1:0]   pp_ext;
  logic [C_RES_W-1:0]   pp_shift;
  logic                 illegal;

  // Digit decode. Zero magnitude (including the illegal 1x&2x code) yields an
  // all-zero magnitude, so negating it still contributes exactly zero.
  always_comb begin
    mag = '0;
    unique case ({Sel_1x_SI, Sel_2x_SI})
      2'b10:   mag = {1'b0, a_q};
      2'b01:   mag = {a_q, 1'b0};
      default: mag = '0;
    endcase
    illegal  = Sel_1x_SI & Sel_2x_SI;
    mag_ext  = {{(C_RES_W - C_WIDTH - 1){1'b0}}, mag};
    pp_ext   = Sel_sign_SI ? ('0 - mag_ext) : mag_ext;
    pp_shift = pp_ext << {cnt_q, 1'b0};
  end

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    Ready_SO        = 1'b0;
    Digit_ready_SO  = 1'b0;
    Result_valid_SO = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        Ready_SO = 1'b1;
        if (Start_SI) begin
          a_d     = Operand_a_DI;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        Digit_ready_SO = 1'b1;
        if (Digit_valid_SI) begin
          acc_d = acc_q + pp_shift;
          if (illegal) begin
            err_d = 1'b1;
          end
          if (cnt_q == LAST_DIG) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        Result_valid_SO = 1'b1;
        if (Result_ready_SI) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign Result_DO = acc_q;
  assign Err_SO    = err_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;

  localparam int unsigned W  = 24;
  localparam int unsigned ND = 13;
  localparam int unsigned RW = W + 2 * ND + 1;

  // Digit codes {sign, 2x, 1x}
  localparam logic [2:0] D_Z  = 3'b000;
  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_P2 = 3'b010;
  localparam logic [2:0] D_M1 = 3'b101;
  localparam logic [2:0] D_M2 = 3'b110;
  localparam logic [2:0] D_NZ = 3'b100;
  localparam logic [2:0] D_IL = 3'b011;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  opa;
  logic          ready;
  logic          dvalid;
  logic          s1x, s2x, ssign;
  logic          dready;
  logic          rvalid;
  logic [RW-1:0] result;
  logic          rready;
  logic          err;

  booth_pp_accumulator #(.C_WIDTH(W), .C_NDIG(ND)) dut (
    .Clk_CI          (clk),
    .Rst_RI          (rst),
    .Start_SI        (start),
    .Operand_a_DI    (opa),
    .Ready_SO        (ready),
    .Digit_valid_SI  (dvalid),
    .Sel_1x_SI       (s1x),
    .Sel_2x_SI       (s2x),
    .Sel_sign_SI     (ssign),
    .Digit_ready_SO  (dready),
    .Result_valid_SO (rvalid),
    .Result_DO       (result),
    .Result_ready_SI (rready),
    .Err_SO          (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ops_sent = 0;
  int ops_seen = 0;

  logic [RW-1:0] exp_res_q[$];
  logic          exp_err_q[$];
  logic [2:0]    digs[ND];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digit(input logic [2:0] d);
    s1x   = d[0];
    s2x   = d[1];
    ssign = d[2];
  endtask

  task automatic clear_digs();
    for (int i = 0; i < int'(ND); i++) digs[i] = D_Z;
  endtask

  // Scoreboard monitor: compares every cycle the result is presented (so it
  // also proves stability while back-pressured) and pops on consumption.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_res_q.size() == 0) begin
        chk("unexpected_result", 64'(result), 64'hDEAD);
      end else begin
        chk("result", 64'(result), 64'(exp_res_q[0]));
        chk("err", 64'(err), 64'(exp_err_q[0]));
        if (rready) begin
          void'(exp_res_q.pop_front());
          void'(exp_err_q.pop_front());
          ops_seen++;
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [RW-1:0] exp_res,
                        input logic exp_err, input bit stall, input int rdelay);
    int n;
    chk("ready_before_start", 64'(ready), 64'd1);
    exp_res_q.push_back(exp_res);
    exp_err_q.push_back(exp_err);
    ops_sent++;
    opa   = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    opa   = '0;
    chk("ready_in_accum", 64'(ready), 64'd0);
    for (int i = 0; i < int'(ND); i++) begin
      if (stall) begin
        n = int'($urandom_range(0, 2));
        repeat (n) begin
          dvalid = 1'b0;
          set_digit(D_P2);
          tick();
        end
        if (i == 3) begin
          // spurious start with a different operand, must be ignored
          dvalid = 1'b0;
          start  = 1'b1;
          opa    = W'(999);
          tick();
          start  = 1'b0;
          opa    = '0;
        end
      end
      chk("digit_ready", 64'(dready), 64'd1);
      if (!stall && i == int'(ND) - 1) chk("early_valid", 64'(rvalid), 64'd0);
      dvalid = 1'b1;
      set_digit(digs[i]);
      tick();
    end
    dvalid = 1'b0;
    set_digit(D_Z);
    if (!stall) begin
      chk("latency_valid", 64'(rvalid), 64'd1);
    end else begin
      n = 0;
      while (!rvalid && n < 50) begin
        tick();
        n++;
      end
      chk("result_valid_timeout", 64'(rvalid), 64'd1);
    end
    // Back-pressure: digits offered in DONE must not be consumed
    for (int k = 0; k < rdelay; k++) begin
      dvalid = 1'b1;
      set_digit(D_P1);
      chk("digit_ready_in_done", 64'(dready), 64'd0);
      tick();
    end
    dvalid = 1'b0;
    set_digit(D_Z);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("ready_after_consume", 64'(ready), 64'd1);
    chk("valid_after_consume", 64'(rvalid), 64'd0);
  endtask

  initial begin
    logic [RW-1:0] e;
    longint        big;

    rst = 1'b1; start = 1'b0; opa = '0; dvalid = 1'b0;
    s1x = 1'b0; s2x = 1'b0; ssign = 1'b0; rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_dready", 64'(dready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_result", 64'(result), 64'd0);

    // A=3, digits +1,+1 -> 3*(1+4) = 15
    clear_digs();
    digs[0] = D_P1; digs[1] = D_P1;
    run_op(W'(3), RW'(15), 1'b0, 1'b0, 0);

    // A=7, -2 then signed zero -> -14
    clear_digs();
    digs[0] = D_M2; digs[1] = D_NZ;
    e = '0 - RW'(14);
    run_op(W'(7), e, 1'b0, 1'b0, 0);

    // A=2^24-1, all +2 -> 2A*(4^13-1)/3 = 2*16777215*22369621
    for (int i = 0; i < int'(ND); i++) digs[i] = D_P2;
    big = longint'(2) * longint'(16777215) * longint'(22369621);
    run_op(W'(24'hFFFFFF), RW'(big), 1'b0, 1'b0, 1);
    for (int i = 0; i < int'(ND); i++) digs[i] = D_M2;
    e = '0 - RW'(big);
    run_op(W'(24'hFFFFFF), e, 1'b0, 1'b0, 0);

    // A=5, illegal digit0, +1 digit1 -> 20, err
    clear_digs();
    digs[0] = D_IL; digs[1] = D_P1;
    run_op(W'(5), RW'(20), 1'b1, 1'b0, 0);
    // clean op clears err: A=5, digit2 -1 -> -80
    clear_digs();
    digs[2] = D_M1;
    e = '0 - RW'(80);
    run_op(W'(5), e, 1'b0, 1'b0, 0);

    // A=1234, +2,-1,+1 -> 1234*(2-4+16) = 17276 ; stalls + spurious start + backpressure
    clear_digs();
    digs[0] = D_P2; digs[1] = D_M1; digs[2] = D_P1;
    run_op(W'(1234), RW'(17276), 1'b0, 1'b1, 5);
    run_op(W'(1234), RW'(17276), 1'b0, 1'b0, 0);

    // Reset after 6 digits: operation discarded
    opa   = W'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dvalid = 1'b1;
      set_digit(D_P1);
      tick();
    end
    dvalid = 1'b0;
    set_digit(D_Z);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    clear_digs();
    digs[0] = D_P1; digs[1] = D_P1;
    run_op(W'(3), RW'(15), 1'b0, 1'b0, 0);

    tick();
    chk("sb_drain", 64'(exp_res_q.size()), 64'd0);
    chk("ops_seen", 64'(ops_seen), 64'(ops_sent));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
